// File: rtl/rfphoenix_ptg_cache_if.sv
// rtl/rfphoenix_ptg_cache_if.sv - lookup/fill/update/invalidate bus of the PTG cache
interface rfphoenix_ptg_cache_if #(
  parameter int AW = 32,
  parameter int GW = 1024
);
  logic          lk_req_i;
  logic [AW-1:0] lk_adr_i;
  logic          lk_ack_o;
  logic          lk_hit_o;
  logic [GW-1:0] lk_ptg_o;
  logic          fill_i;
  logic [AW-1:0] fill_adr_i;
  logic [GW-1:0] fill_ptg_i;
  logic          upd_i;
  logic [AW-1:0] upd_adr_i;
  logic [127:0]  upd_pte_i;
  logic          inv_all_i;
  logic          inv_i;
  logic [AW-1:0] inv_adr_i;
  logic [31:0]   hit_cnt_o;
  logic [31:0]   miss_cnt_o;

  modport master (
    output lk_req_i, lk_adr_i, fill_i, fill_adr_i, fill_ptg_i,
           upd_i, upd_adr_i, upd_pte_i, inv_all_i, inv_i, inv_adr_i,
    input  lk_ack_o, lk_hit_o, lk_ptg_o, hit_cnt_o, miss_cnt_o
  );

  modport slave (
    input  lk_req_i, lk_adr_i, fill_i, fill_adr_i, fill_ptg_i,
           upd_i, upd_adr_i, upd_pte_i, inv_all_i, inv_i, inv_adr_i,
    output lk_ack_o, lk_hit_o, lk_ptg_o, hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/rfphoenix_ptg_cache.sv
// rtl/rfphoenix_ptg_cache.sv - fully associative cache of hashed page-table groups
module rfphoenix_ptg_cache #(
  parameter int DEP  = 8,
  parameter int PTES = 8,
  parameter int AW   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  rfphoenix_ptg_cache_if.slave   bus
);
  localparam int GW = PTES * 128;
  localparam int OB = $clog2(PTES * 16);
  localparam int TW = AW - OB;
  localparam int IW = $clog2(DEP);
  localparam int SW = $clog2(PTES);

  logic [TW-1:0]          tag_q  [DEP];
  logic [PTES-1:0][127:0] data_q [DEP];
  logic [DEP-1:0]         vld_q, vld_d;
  logic [IW-1:0]          rr_q, rr_d;

  logic [DEP-1:0] lk_m, fill_m, upd_m, inv_m, fill_we, upd_we;
  logic [IW-1:0]  fill_idx;
  logic           fill_rr, found;
  logic [GW-1:0]  lk_data;
  logic [SW-1:0]  upd_slot;

  logic           ack_q, hit_q;
  logic [GW-1:0]  ptg_q;
  logic [31:0]    hit_cnt_q, miss_cnt_q;

  logic unused_adr_bits;
  assign unused_adr_bits = ^{bus.lk_adr_i[OB-1:0], bus.fill_adr_i[OB-1:0],
                             bus.upd_adr_i[3:0], bus.inv_adr_i[OB-1:0]};
  assign upd_slot = bus.upd_adr_i[OB-1:4];

  // Tag compares for all four ports and the OR-merge of the (single) hit entry.
  always_comb begin
    lk_data = '0;
    for (int e = 0; e < DEP; e++) begin
      lk_m[e]   = vld_q[e] && (tag_q[e] == bus.lk_adr_i[AW-1:OB]);
      fill_m[e] = vld_q[e] && (tag_q[e] == bus.fill_adr_i[AW-1:OB]);
      upd_m[e]  = vld_q[e] && (tag_q[e] == bus.upd_adr_i[AW-1:OB]);
      inv_m[e]  = vld_q[e] && (tag_q[e] == bus.inv_adr_i[AW-1:OB]);
      if (lk_m[e]) lk_data = lk_data | data_q[e];
    end
  end

  // Fill victim: existing tag first, then lowest invalid entry, else round-robin.
  always_comb begin
    fill_idx = rr_q;
    fill_rr  = 1'b1;
    found    = 1'b0;
    for (int e = 0; e < DEP; e++) begin
      if (!found && fill_m[e]) begin
        fill_idx = IW'(e);
        found    = 1'b1;
        fill_rr  = 1'b0;
      end
    end
    for (int e = 0; e < DEP; e++) begin
      if (!found && !vld_q[e]) begin
        fill_idx = IW'(e);
        found    = 1'b1;
        fill_rr  = 1'b0;
      end
    end
  end

  // Per-entry write enables: inv_all > inv > fill > upd; collisions drop the weaker op.
  always_comb begin
    fill_we = '0;
    upd_we  = '0;
    vld_d   = vld_q;
    rr_d    = rr_q;
    if (bus.inv_all_i) begin
      vld_d = '0;
    end else begin
      for (int e = 0; e < DEP; e++) begin
        fill_we[e] = bus.fill_i && (fill_idx == IW'(e)) && !(bus.inv_i && inv_m[e]);
        upd_we[e]  = bus.upd_i && upd_m[e] && !(bus.inv_i && inv_m[e]) && !fill_we[e];
        if (bus.inv_i && inv_m[e]) vld_d[e] = 1'b0;
        if (fill_we[e]) vld_d[e] = 1'b1;
      end
      if (fill_rr && |fill_we) rr_d = rr_q + 1'b1;
    end
  end

  // Entry payload: tags and data are intentionally not reset.
  always_ff @(posedge clk_i) begin
    for (int e = 0; e < DEP; e++) begin
      if (fill_we[e]) begin
        tag_q[e]  <= bus.fill_adr_i[AW-1:OB];
        data_q[e] <= bus.fill_ptg_i;
      end else if (upd_we[e]) begin
        data_q[e][upd_slot] <= bus.upd_pte_i;
      end
    end
  end

  // Valid bits, replacement pointer, registered lookup result and statistics.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q      <= '0;
      rr_q       <= '0;
      ack_q      <= 1'b0;
      hit_q      <= 1'b0;
      ptg_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      rr_q  <= rr_d;
      ack_q <= bus.lk_req_i;
      if (bus.lk_req_i) begin
        hit_q <= |lk_m;
        ptg_q <= lk_data;
        if (|lk_m) begin
          if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
        end else begin
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
      end
    end
  end

  assign bus.lk_ack_o   = ack_q;
  assign bus.lk_hit_o   = hit_q;
  assign bus.lk_ptg_o   = ptg_q;
  assign bus.hit_cnt_o  = hit_cnt_q;
  assign bus.miss_cnt_o = miss_cnt_q;
endmodule
